// File: rtl/multi_noc_pkg.sv
// Shared defaults and steering-mode encoding for the multi-subnet injection steer.
package multi_noc_pkg;

  localparam int DEF_NUM_NOC    = 2;
  localparam int DEF_WIDTH_PORT = 64;
  localparam int DEF_CREDITS    = 4;

  // Wide enough for the largest legal credit pool (15).
  localparam int CNT_W = 4;

  typedef enum logic {
    RR           = 1'b0,
    LEAST_LOADED = 1'b1
  } steer_mode_e;

endpackage

// File: rtl/multi_noc_steer_if.sv
// Core-side handshake, subnet injection/credit and bypass-ring signal bundle.
interface multi_noc_steer_if #(
  parameter int NUM_NOC    = multi_noc_pkg::DEF_NUM_NOC,
  parameter int WIDTH_PORT = multi_noc_pkg::DEF_WIDTH_PORT
);

  logic                          in_valid;
  logic [WIDTH_PORT-1:0]         in_flit;
  logic                          in_ready;
  logic                          mode_sel;
  logic [NUM_NOC-1:0]            inj_valid;
  logic [NUM_NOC*WIDTH_PORT-1:0] inj_flit;
  logic [NUM_NOC-1:0]            inj_credit;
  logic [NUM_NOC-1:0]            byp_in_valid;
  logic [NUM_NOC*WIDTH_PORT-1:0] byp_in_flit;
  logic [NUM_NOC-1:0]            byp_out_valid;
  logic [NUM_NOC*WIDTH_PORT-1:0] byp_out_flit;
  logic                          credit_err;

  modport slave (
    input  in_valid, in_flit, mode_sel, inj_credit, byp_in_valid, byp_in_flit,
    output in_ready, inj_valid, inj_flit, byp_out_valid, byp_out_flit, credit_err
  );

  modport master (
    output in_valid, in_flit, mode_sel, inj_credit, byp_in_valid, byp_in_flit,
    input  in_ready, inj_valid, inj_flit, byp_out_valid, byp_out_flit, credit_err
  );

endinterface

// File: rtl/noc_credit_counter.sv
// Per-subnet injection credit counter: saturates at CREDITS, sticky overflow on excess return.
module noc_credit_counter
  import multi_noc_pkg::*;
#(
  parameter int CREDITS = DEF_CREDITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= CNT_W'(CREDITS);
      ovf <= 1'b0;
    end else if (inc && !dec) begin
      // A return beyond the pool means the subnet over-credited us; hold and flag.
      if (cnt == CNT_W'(CREDITS)) ovf <= 1'b1;
      else                        cnt <= cnt + CNT_W'(1);
    end else if (dec && !inc && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/multi_noc_steer.sv
// Steers core flits onto one of NUM_NOC subnets (round-robin or least-loaded by
// credit count) and forwards a registered bypass ring between the subnets.
module multi_noc_steer
  import multi_noc_pkg::*;
#(
  parameter int NUM_NOC    = DEF_NUM_NOC,
  parameter int WIDTH_PORT = DEF_WIDTH_PORT,
  parameter int CREDITS    = DEF_CREDITS
) (
  input logic              clk,
  input logic              reset,
  multi_noc_steer_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_NOC);

  logic [CNT_W-1:0]      cnt [NUM_NOC];
  logic [NUM_NOC-1:0]    elig;
  logic [NUM_NOC-1:0]    err_vec;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      sel;
  logic [IDX_W-1:0]      idx;
  logic [CNT_W-1:0]      best;
  logic                  found;
  int                    s;
  logic                  xfer;

  logic [NUM_NOC-1:0]    inj_vld_p1;
  logic [WIDTH_PORT-1:0] inj_flit_p1 [NUM_NOC];
  logic                  byp_vld_p1  [NUM_NOC];
  logic [WIDTH_PORT-1:0] byp_flit_p1 [NUM_NOC];

  for (genvar i = 0; i < NUM_NOC; i++) begin : g_credit
    noc_credit_counter #(.CREDITS(CREDITS)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .dec   (xfer && (sel == IDX_W'(i))),
      .inc   (bus.inj_credit[i]),
      .cnt   (cnt[i]),
      .ovf   (err_vec[i])
    );
    assign elig[i] = (cnt[i] != '0);
  end

  // in_ready depends only on registered credit state, never on in_valid.
  assign bus.in_ready   = |elig;
  assign bus.credit_err = |err_vec;
  assign xfer           = bus.in_valid && bus.in_ready;

  // Scan from rr_ptr; strict '>' keeps ties on the earliest index in scan order.
  always_comb begin
    sel   = '0;
    idx   = '0;
    best  = '0;
    found = 1'b0;
    s     = 0;
    for (int k = 0; k < NUM_NOC; k++) begin
      s = int'(rr_ptr) + k;
      if (s >= NUM_NOC) s = s - NUM_NOC;
      idx = IDX_W'(s);
      if (elig[idx]) begin
        if (steer_mode_e'(bus.mode_sel) == RR) begin
          if (!found) begin
            sel   = idx;
            found = 1'b1;
          end
        end else if (!found || cnt[idx] > best) begin
          sel   = idx;
          best  = cnt[idx];
          found = 1'b1;
        end
      end
    end
  end

  // Stage p0 -> p1: registered injection strobe and flit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr      <= '0;
      inj_vld_p1  <= '0;
      inj_flit_p1 <= '{default: '0};
    end else begin
      inj_vld_p1 <= '0;
      if (xfer) begin
        inj_vld_p1[sel]  <= 1'b1;
        inj_flit_p1[sel] <= bus.in_flit;
        rr_ptr           <= (sel == IDX_W'(NUM_NOC - 1)) ? '0 : sel + IDX_W'(1);
      end
    end
  end

  // Stage p0 -> p1: bypass ring, subnet i feeds subnet (i+1) mod NUM_NOC.
  for (genvar i = 0; i < NUM_NOC; i++) begin : g_byp
    localparam int J = (i + 1) % NUM_NOC;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        byp_vld_p1[J]  <= 1'b0;
        byp_flit_p1[J] <= '0;
      end else begin
        byp_vld_p1[J] <= bus.byp_in_valid[i];
        if (bus.byp_in_valid[i]) byp_flit_p1[J] <= bus.byp_in_flit[i*WIDTH_PORT +: WIDTH_PORT];
      end
    end
  end

  assign bus.inj_valid = inj_vld_p1;
  for (genvar i = 0; i < NUM_NOC; i++) begin : g_out
    assign bus.inj_flit[i*WIDTH_PORT +: WIDTH_PORT]     = inj_flit_p1[i];
    assign bus.byp_out_valid[i]                         = byp_vld_p1[i];
    assign bus.byp_out_flit[i*WIDTH_PORT +: WIDTH_PORT] = byp_flit_p1[i];
  end

endmodule

// File: tb/tb_multi_noc_steer.sv
// Directed checks of steering, credits, overflow, bypass ring and async reset.
module tb_multi_noc_steer;

  localparam int W = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  multi_noc_steer_if #(.NUM_NOC(4), .WIDTH_PORT(W)) b4 ();
  multi_noc_steer_if #(.NUM_NOC(3), .WIDTH_PORT(W)) b3 ();

  multi_noc_steer #(.NUM_NOC(4), .WIDTH_PORT(W), .CREDITS(2)) u4 (
    .clk(clk), .reset(reset), .bus(b4)
  );
  multi_noc_steer #(.NUM_NOC(3), .WIDTH_PORT(W), .CREDITS(4)) u3 (
    .clk(clk), .reset(reset), .bus(b3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    b4.in_valid = 0; b4.in_flit = '0; b4.mode_sel = 0; b4.inj_credit = '0;
    b4.byp_in_valid = '0; b4.byp_in_flit = '0;
    b3.in_valid = 0; b3.in_flit = '0; b3.mode_sel = 0; b3.inj_credit = '0;
    b3.byp_in_valid = '0; b3.byp_in_flit = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (b4.inj_valid !== 4'b0) $display("FAIL reset_inj_valid got %b want 0000", b4.inj_valid); else passed++;
    total++; if (b4.inj_flit !== '0) $display("FAIL reset_inj_flit got %h want 0", b4.inj_flit); else passed++;
    total++; if (b4.byp_out_valid !== 4'b0) $display("FAIL reset_byp_valid got %b want 0000", b4.byp_out_valid); else passed++;
    total++; if (b4.credit_err !== 1'b0) $display("FAIL reset_credit_err got %b want 0", b4.credit_err); else passed++;
    total++; if (b4.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", b4.in_ready); else passed++;
    total++; if (u4.cnt[3] !== 4'd2) $display("FAIL reset_cnt3 got %0d want 2", u4.cnt[3]); else passed++;
  endtask

  task automatic test_rr_sequence();
    logic [W-1:0] f;
    do_reset();
    b4.in_valid = 1;
    b4.in_flit = 16'hA000;
    for (int n = 0; n < 8; n++) begin
      step();
      f = 16'hA000 + W'(n);
      total++; if (b4.inj_valid !== 4'(1 << (n % 4))) $display("FAIL rr_onehot n=%0d got %b want %b", n, b4.inj_valid, 4'(1 << (n % 4))); else passed++;
      total++; if (b4.inj_flit[(n % 4)*W +: W] !== f) $display("FAIL rr_flit n=%0d got %h want %h", n, b4.inj_flit[(n % 4)*W +: W], f); else passed++;
      b4.in_flit = 16'hA000 + W'(n + 1);
    end
    total++; if (b4.in_ready !== 1'b0) $display("FAIL rr_exhausted_ready got %b want 0", b4.in_ready); else passed++;
    step();
    total++; if (b4.inj_valid !== 4'b0) $display("FAIL rr_no_xfer got %b want 0000", b4.inj_valid); else passed++;
    total++; if (b4.inj_flit[0 +: W] !== 16'hA004) $display("FAIL rr_slice_hold got %h want a004", b4.inj_flit[0 +: W]); else passed++;
    b4.in_valid = 0;
  endtask

  task automatic test_least_loaded();
    do_reset();
    b4.in_valid = 1;
    repeat (5) step();
    b4.in_valid = 0;
    b4.inj_credit = 4'b1101; step();
    b4.inj_credit = 4'b0001; step();
    b4.inj_credit = 4'b0000;
    total++; if (u4.cnt[1] !== 4'd1 || u4.cnt[0] !== 4'd2) $display("FAIL ll_setup got cnt0=%0d cnt1=%0d want 2,1", u4.cnt[0], u4.cnt[1]); else passed++;
    b4.mode_sel = 1; b4.in_valid = 1; b4.in_flit = 16'hBEEF; b4.inj_credit = 4'b0010;
    step();
    b4.in_valid = 0; b4.inj_credit = 4'b0000;
    total++; if (b4.inj_valid !== 4'b0100) $display("FAIL ll_select got %b want 0100", b4.inj_valid); else passed++;
    total++; if (b4.inj_flit[2*W +: W] !== 16'hBEEF) $display("FAIL ll_flit got %h want beef", b4.inj_flit[2*W +: W]); else passed++;
    total++; if (u4.cnt[1] !== 4'd2) $display("FAIL ll_cnt1 got %0d want 2", u4.cnt[1]); else passed++;
    total++; if (u4.cnt[2] !== 4'd1) $display("FAIL ll_cnt2 got %0d want 1", u4.cnt[2]); else passed++;
    total++; if (b4.credit_err !== 1'b0) $display("FAIL ll_no_err got %b want 0", b4.credit_err); else passed++;
    b4.mode_sel = 0; b4.in_valid = 1; step();
    total++; if (b4.inj_valid !== 4'b1000) $display("FAIL ll_rrptr_after got %b want 1000", b4.inj_valid); else passed++;
    b4.mode_sel = 1; step();
    b4.in_valid = 0;
    total++; if (b4.inj_valid !== 4'b0001) $display("FAIL ll_tie got %b want 0001", b4.inj_valid); else passed++;
  endtask

  task automatic test_same_cycle();
    do_reset();
    b4.in_valid = 1;
    repeat (2) step();
    b4.inj_credit = 4'b0100;
    step();
    b4.in_valid = 0; b4.inj_credit = 4'b0000;
    total++; if (b4.inj_valid !== 4'b0100) $display("FAIL same_inj got %b want 0100", b4.inj_valid); else passed++;
    total++; if (u4.cnt[2] !== 4'd2) $display("FAIL same_cnt2 got %0d want 2", u4.cnt[2]); else passed++;
    total++; if (b4.credit_err !== 1'b0) $display("FAIL same_no_err got %b want 0", b4.credit_err); else passed++;
  endtask

  task automatic test_overflow();
    do_reset();
    b4.inj_credit = 4'b1000;
    step();
    b4.inj_credit = 4'b0000;
    total++; if (u4.cnt[3] !== 4'd2) $display("FAIL ovf_cnt3 got %0d want 2", u4.cnt[3]); else passed++;
    total++; if (b4.credit_err !== 1'b1) $display("FAIL ovf_flag got %b want 1", b4.credit_err); else passed++;
    repeat (3) step();
    total++; if (b4.credit_err !== 1'b1) $display("FAIL ovf_sticky got %b want 1", b4.credit_err); else passed++;
  endtask

  task automatic test_bypass();
    do_reset();
    b3.byp_in_valid = 3'b101;
    b3.byp_in_flit = {16'hCCCC, 16'h5555, 16'hAAAA};
    step();
    b3.byp_in_valid = 3'b010;
    b3.byp_in_flit = {16'h1234, 16'hBBBB, 16'h4321};
    total++; if (b3.byp_out_valid !== 3'b011) $display("FAIL byp_valid got %b want 011", b3.byp_out_valid); else passed++;
    total++; if (b3.byp_out_flit[1*W +: W] !== 16'hAAAA) $display("FAIL byp_sub1 got %h want aaaa", b3.byp_out_flit[1*W +: W]); else passed++;
    total++; if (b3.byp_out_flit[0 +: W] !== 16'hCCCC) $display("FAIL byp_sub0 got %h want cccc", b3.byp_out_flit[0 +: W]); else passed++;
    step();
    b3.byp_in_valid = 3'b000;
    total++; if (b3.byp_out_valid !== 3'b100) $display("FAIL byp_b2b_valid got %b want 100", b3.byp_out_valid); else passed++;
    total++; if (b3.byp_out_flit[2*W +: W] !== 16'hBBBB) $display("FAIL byp_b2b_flit got %h want bbbb", b3.byp_out_flit[2*W +: W]); else passed++;
    total++; if (b3.byp_out_flit[1*W +: W] !== 16'hAAAA) $display("FAIL byp_hold got %h want aaaa", b3.byp_out_flit[1*W +: W]); else passed++;
    step();
    total++; if (b3.byp_out_valid !== 3'b000) $display("FAIL byp_idle got %b want 000", b3.byp_out_valid); else passed++;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    b4.in_valid = 1; b4.in_flit = 16'h7777;
    b4.byp_in_valid = 4'b0001; b4.byp_in_flit = {48'h0, 16'h9999};
    step();
    step();
    total++; if (b4.inj_valid === 4'b0 || b4.byp_out_valid === 4'b0) $display("FAIL mid_active got inj=%b byp=%b want both nonzero", b4.inj_valid, b4.byp_out_valid); else passed++;
    #2 reset = 1'b0;
    #1;
    total++; if (b4.inj_valid !== 4'b0) $display("FAIL mid_inj_valid got %b want 0000", b4.inj_valid); else passed++;
    total++; if (b4.inj_flit !== '0) $display("FAIL mid_inj_flit got %h want 0", b4.inj_flit); else passed++;
    total++; if (b4.byp_out_valid !== 4'b0) $display("FAIL mid_byp_valid got %b want 0000", b4.byp_out_valid); else passed++;
    total++; if (b4.byp_out_flit !== '0) $display("FAIL mid_byp_flit got %h want 0", b4.byp_out_flit); else passed++;
    total++; if (u4.cnt[0] !== 4'd2 || u4.cnt[1] !== 4'd2) $display("FAIL mid_cnt got %0d,%0d want 2,2", u4.cnt[0], u4.cnt[1]); else passed++;
    clear_inputs();
    step();
    reset = 1'b1;
    #1;
    total++; if (b4.in_ready !== 1'b1) $display("FAIL mid_ready got %b want 1", b4.in_ready); else passed++;
    step();
    total++; if (b4.inj_valid !== 4'b0) $display("FAIL mid_no_replay got %b want 0000", b4.inj_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_rr_sequence();
    test_least_loaded();
    test_same_cycle();
    test_overflow();
    test_bypass();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multi_noc_steer.md
MULTI_NOC_STEER -- requirements
Module: multi_noc_steer

Interface
REQ-001 Parameter NUM_NOC, default 2: number of parallel subnetworks; legal range 2..8.
REQ-002 Parameter WIDTH_PORT, default 64: flit width in bits.
REQ-003 Parameter CREDITS, default 4: injection credits per subnetwork; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  local core offers a flit.
REQ-007 in_flit  input  WIDTH_PORT  offered flit.
REQ-008 in_ready  output  1  block accepts in_flit this cycle.
REQ-009 mode_sel  input  1  steering mode: 0 = round-robin, 1 = least-loaded.
REQ-010 inj_valid  output  NUM_NOC  one-hot injection strobe to subnet local ports.
REQ-011 inj_flit  output  NUM_NOC*WIDTH_PORT  injected flit; slice i goes to subnet i.
REQ-012 inj_credit  input  NUM_NOC  one-cycle credit-return pulse per subnet.
REQ-013 byp_in_valid  input  NUM_NOC  bypass flit valid from subnet i.
REQ-014 byp_in_flit  input  NUM_NOC*WIDTH_PORT  bypass flit from subnet i.
REQ-015 byp_out_valid  output  NUM_NOC  bypass flit valid into subnet i.
REQ-016 byp_out_flit  output  NUM_NOC*WIDTH_PORT  bypass flit into subnet i.
REQ-017 credit_err  output  1  sticky credit-overflow flag.

Function
REQ-018 Each subnet i SHALL have a credit counter cnt[i] (0..CREDITS): -1 on injection to i; +1 on inj_credit[i]; both in the same cycle -> unchanged.
REQ-019 A credit pulse while cnt[i]==CREDITS with no same-cycle injection to i SHALL leave cnt[i] at CREDITS and set credit_err.
REQ-020 Subnet i is eligible when cnt[i]>0; in_ready SHALL be 1 iff at least one subnet is eligible, combinational from registered state only (never from in_valid).
REQ-021 Transfer occurs when in_valid && in_ready; in_flit SHALL be held stable by the source until transfer.
REQ-022 mode_sel=0: selected subnet SHALL be the first eligible index scanning rr_ptr, rr_ptr+1, ... modulo NUM_NOC.
REQ-023 mode_sel=1: selected subnet SHALL be the eligible index with the largest cnt; ties go to the first in the rr_ptr scan order.
REQ-024 On every transfer rr_ptr SHALL become (sel+1) mod NUM_NOC, in both modes; no transfer -> rr_ptr held.
REQ-025 Transfer in cycle t SHALL produce inj_valid[sel]=1 with inj_flit slice sel = in_flit in cycle t+1 only; all other inj_valid bits 0.
REQ-026 Inactive inj_flit slices SHALL hold their last value.
REQ-027 Bypass ring: byp_out_valid[(i+1) mod NUM_NOC] SHALL equal byp_in_valid[i] delayed exactly one cycle, for all i.
REQ-028 byp_out_flit slice (i+1) mod NUM_NOC SHALL load byp_in_flit slice i when byp_in_valid[i]=1, else hold.
REQ-029 Bypass path SHALL never stall or drop a valid flit; it is independent of the injection logic.
REQ-030 mode_sel changes SHALL take effect on the next selection with no state flush.

Reset
REQ-031 Asserting reset SHALL asynchronously force: inj_valid=0, inj_flit=0, byp_out_valid=0, byp_out_flit=0, cnt[i]=CREDITS, rr_ptr=0, credit_err=0.
REQ-032 Flits in flight at reset (registered injection or bypass) SHALL be discarded; in_ready SHALL be 1 in the first cycle after reset release.
REQ-033 credit_err SHALL clear only by reset.

Structure
REQ-034 Package multi_noc_pkg SHALL hold default NUM_NOC, WIDTH_PORT, CREDITS, and the steering-mode constants RR=0, LEAST_LOADED=1.
REQ-035 One sub-module noc_credit_counter (saturating up/down counter with overflow flag) SHALL be instantiated per subnet; selection and bypass logic stay in multi_noc_steer.

Verification
REQ-036 NUM_NOC=4, CREDITS=2, mode 0, in_valid held 1, no credit returns -> inj_valid sequence 0001,0010,0100,1000,0001,...,1000 over 8 cycles, then in_ready=0.
REQ-037 Mode 1, cnt={2,1,2,2} (i=0..3), rr_ptr=1 -> selects subnet 2; credit returned to 1 in the same cycle -> cnt[1]=2, no error.
REQ-038 cnt[3]=CREDITS, inj_credit[3] pulse, no injection -> cnt[3] unchanged, credit_err=1 next cycle and stays 1.
REQ-039 NUM_NOC=3, byp_in_valid=101 with flits A,-,C at cycle t -> cycle t+1: byp_out_valid=011, subnet1 gets A, subnet0 gets C.
REQ-040 Injection to subnet 2 and inj_credit[2] in the same cycle -> cnt[2] unchanged, inj_valid[2]=1 next cycle.
REQ-041 Reset asserted mid-stream with inj_valid and byp_out_valid set -> all outputs 0 immediately (asynchronous), credits restored to CREDITS, in_ready=1 after release.
